// File: rtl/store_align_unit.sv
// -----------------------------------------------------------------------------
// store_align_unit
//
// Purpose:
//   Store-side alignment stage between execute/memory and the data-memory
//   write port. An accepted store (address, rs2 data, funct3) is shifted into
//   its byte lanes, given a byte write mask, and issued to memory over a
//   req/ack handshake. A store that crosses a word boundary is issued as two
//   word-aligned beats. Completion or fault is reported back with a one-cycle
//   done pulse.
//
// Parameters:
//   MISALIGN_SPLIT  1: split word-crossing stores into two beats
//                   0: word-crossing stores fault without touching memory
//
// Ports:
//   clk         clock, rising edge
//   rst         synchronous reset, active-high
//   in_valid    store request valid
//   in_ready    unit idle and able to accept a request
//   in_addr     byte address of the store
//   in_data     rs2 value, store data in the low bits
//   in_funct3   000 sb, 001 sh, 010 sw; anything else is illegal
//   mem_req     memory write request
//   mem_addr    word-aligned beat address
//   mem_wdata   lane-aligned beat data
//   mem_wmask   byte enables, bit i = byte lane i (zero when no request)
//   mem_ack     memory accepted the current beat (ignored without mem_req)
//   done_valid  one-cycle pulse: store finished or faulted
//   done_fault  qualifies done_valid: illegal funct3 or unsplittable store
//   busy        unit is not idle
// -----------------------------------------------------------------------------
module store_align_unit #(
  parameter bit MISALIGN_SPLIT = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_data,
  input  logic [2:0]  in_funct3,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_ack,
  output logic        done_valid,
  output logic        done_fault,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ1 = 2'd1,
    S_REQ2 = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;

  // Current beat (drives the memory port directly) and the pending second beat.
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wmask;
  logic [31:0] r_wdata2;
  logic [3:0]  r_wmask2;
  logic        r_split;
  logic        r_fault;

  logic [3:0]  w_size_mask;
  logic        w_legal;
  logic [7:0]  w_mask8;
  logic [63:0] w_data64;
  logic        w_cross;
  logic        w_fault_in;
  logic        w_accept;
  logic        w_beat_ack;

  // Lane shifting over a two-word window: the upper half is the second beat.
  always_comb begin
    w_size_mask = 4'b0000;
    w_legal     = 1'b1;
    case (in_funct3)
      3'b000:  w_size_mask = 4'b0001;
      3'b001:  w_size_mask = 4'b0011;
      3'b010:  w_size_mask = 4'b1111;
      default: w_legal     = 1'b0;
    endcase
  end

  assign w_mask8    = {4'b0000, w_size_mask} << in_addr[1:0];
  assign w_data64   = {32'b0, in_data} << {in_addr[1:0], 3'b000};
  assign w_cross    = |w_mask8[7:4];
  assign w_fault_in = !w_legal || (w_cross && !MISALIGN_SPLIT);
  assign w_accept   = in_valid && (r_state == S_IDLE);
  assign w_beat_ack = mem_ack && ((r_state == S_REQ1) || (r_state == S_REQ2));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next = w_fault_in ? S_RESP : S_REQ1;
        end
      end
      S_REQ1: begin
        if (mem_ack) begin
          w_next = r_split ? S_REQ2 : S_RESP;
        end
      end
      S_REQ2: begin
        if (mem_ack) begin
          w_next = S_RESP;
        end
      end
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready   = (r_state == S_IDLE);
    busy       = (r_state != S_IDLE);
    mem_req    = (r_state == S_REQ1) || (r_state == S_REQ2);
    done_valid = (r_state == S_RESP);
    done_fault = (r_state == S_RESP) && r_fault;
    mem_wmask  = mem_req ? r_wmask : 4'b0000;
    mem_addr   = r_addr;
    mem_wdata  = r_wdata;
  end

  // Beat fields: captured once at accept, then swapped to the second beat when
  // the first beat of a split store is acked. Nothing is taken from the inputs
  // after accept, so the port stays stable while a beat waits for its ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr  <= 32'h0;
      r_wdata <= 32'h0;
      r_wmask <= 4'b0000;
      r_fault <= 1'b0;
    end else if (w_accept) begin
      r_addr  <= {in_addr[31:2], 2'b00};
      r_wdata <= w_data64[31:0];
      r_wmask <= w_mask8[3:0];
      r_fault <= w_fault_in;
    end else if (w_beat_ack && (r_state == S_REQ1) && r_split) begin
      // Wraps naturally from 0xFFFFFFFC to 0x00000000.
      r_addr  <= r_addr + 32'd4;
      r_wdata <= r_wdata2;
      r_wmask <= r_wmask2;
    end
  end

  // Second-beat data only matters after an accept, so it needs no reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_wdata2 <= w_data64[63:32];
      r_wmask2 <= w_mask8[7:4];
      r_split  <= w_cross;
    end
  end

endmodule

// File: tb/tb_store_align_unit.sv
// -----------------------------------------------------------------------------
// tb_store_align_unit
//
// Scoreboard bench for store_align_unit. Stimulus pushes the expected memory
// beats and done responses (with the absolute cycle the done pulse must
// appear in); a monitor on the falling edge pops and compares them whenever
// a DUT presents an acked beat or a done pulse. A second instance runs with
// MISALIGN_SPLIT=0.
// -----------------------------------------------------------------------------
module tb_store_align_unit;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
  } beat_t;

  typedef struct {
    logic fault;
    int   cyc;
  } done_t;

  logic        clk;
  logic        rst;

  logic        in_valid, in_ready;
  logic [31:0] in_addr, in_data;
  logic [2:0]  in_funct3;
  logic        mem_req, mem_ack;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wmask;
  logic        done_valid, done_fault, busy;

  logic        in_valid1, in_ready1;
  logic [31:0] in_addr1, in_data1;
  logic [2:0]  in_funct31;
  logic        mem_req1, mem_ack1;
  logic [31:0] mem_addr1, mem_wdata1;
  logic [3:0]  mem_wmask1;
  logic        done_valid1, done_fault1, busy1;

  int    cyc;
  int    n_checks;
  int    n_fail;
  beat_t beat_q[$];
  done_t done_q[$];
  done_t done_q1[$];

  store_align_unit #(.MISALIGN_SPLIT(1'b1)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_data(in_data), .in_funct3(in_funct3),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_ack(mem_ack),
    .done_valid(done_valid), .done_fault(done_fault), .busy(busy)
  );

  store_align_unit #(.MISALIGN_SPLIT(1'b0)) u_dut_nosplit (
    .clk(clk), .rst(rst),
    .in_valid(in_valid1), .in_ready(in_ready1),
    .in_addr(in_addr1), .in_data(in_data1), .in_funct3(in_funct31),
    .mem_req(mem_req1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_wmask(mem_wmask1), .mem_ack(mem_ack1),
    .done_valid(done_valid1), .done_fault(done_fault1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%08h expected=0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: unexpected event (cycle %0d)", name, cyc);
  endtask

  // Monitor: compares every acked beat and every done pulse against the queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_req) begin
        if (beat_q.size() == 0) begin
          flag("unexpected_mem_req");
        end else if (mem_ack) begin
          beat_t b;
          b = beat_q.pop_front();
          chk("beat_addr", mem_addr, b.addr);
          chk("beat_wdata", mem_wdata, b.wdata);
          chk("beat_wmask", {28'h0, mem_wmask}, {28'h0, b.mask});
        end
      end else begin
        chk("idle_wmask", {28'h0, mem_wmask}, 32'h0);
      end
      if (done_valid) begin
        if (done_q.size() == 0) begin
          flag("unexpected_done");
        end else begin
          done_t d;
          d = done_q.pop_front();
          chk("done_fault", {31'h0, done_fault}, {31'h0, d.fault});
          chk("done_cycle", cyc, d.cyc);
        end
      end
      if (mem_req1) flag("nosplit_unexpected_mem_req");
      if (done_valid1) begin
        if (done_q1.size() == 0) begin
          flag("nosplit_unexpected_done");
        end else begin
          done_t d;
          d = done_q1.pop_front();
          chk("nosplit_done_fault", {31'h0, done_fault1}, {31'h0, d.fault});
          chk("nosplit_done_cycle", cyc, d.cyc);
        end
      end
    end
  end

  // Presents one request on the split instance; called just after a rising edge.
  // Returns the accept cycle, or -1 if the unit never became ready.
  task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f,
                      output int acc);
    int w;
    w = 0;
    while (!in_ready && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    if (!in_ready) begin
      flag("send_ready_timeout");
      acc = -1;
    end else begin
      in_addr   = a;
      in_data   = d;
      in_funct3 = f;
      in_valid  = 1'b1;
      acc       = cyc;
      @(posedge clk); #1;
      in_valid  = 1'b0;
    end
  endtask

  task automatic push_beat(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    beat_t b;
    b.addr  = a;
    b.wdata = d;
    b.mask  = m;
    beat_q.push_back(b);
  endtask

  task automatic push_done(input logic f, input int c);
    done_t d;
    d.fault = f;
    d.cyc   = c;
    done_q.push_back(d);
  endtask

  task automatic push_done1(input logic f, input int c);
    done_t d;
    d.fault = f;
    d.cyc   = c;
    done_q1.push_back(d);
  endtask

  // Bounded drain: waits until all expectations are consumed and the unit is idle.
  task automatic drain(input string name);
    int w;
    w = 0;
    while ((beat_q.size() != 0 || done_q.size() != 0 || done_q1.size() != 0 || !in_ready)
           && w < 40) begin
      @(posedge clk); #1;
      w++;
    end
    chk({name, "_beats_left"}, beat_q.size(), 0);
    chk({name, "_dones_left"}, done_q.size() + done_q1.size(), 0);
  endtask

  initial begin
    int acc;
    n_checks   = 0;
    n_fail     = 0;
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_addr    = 32'h0;
    in_data    = 32'h0;
    in_funct3  = 3'b000;
    mem_ack    = 1'b1;
    in_valid1  = 1'b0;
    in_addr1   = 32'h0;
    in_data1   = 32'h0;
    in_funct31 = 3'b000;
    mem_ack1   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_mem_wmask", {28'h0, mem_wmask}, 32'h0);
    chk("rst_done_valid", {31'h0, done_valid}, 32'h0);
    chk("rst_done_fault", {31'h0, done_fault}, 32'h0);
    @(posedge clk); #1;

    // sw aligned, immediate ack: done two cycles after accept
    push_beat(32'h0000_0100, 32'hDEAD_BEEF, 4'b1111);
    send(32'h0000_0100, 32'hDEAD_BEEF, 3'b010, acc);
    push_done(1'b0, acc + 2);
    drain("sw_aligned");

    // sb to top lane
    push_beat(32'h0000_0200, 32'hAB00_0000, 4'b1000);
    send(32'h0000_0203, 32'h0000_00AB, 3'b000, acc);
    push_done(1'b0, acc + 2);
    drain("sb_lane3");

    // sh crossing a word: two beats, done three cycles after accept
    push_beat(32'h0000_0100, 32'h3400_0000, 4'b1000);
    push_beat(32'h0000_0104, 32'h0000_0012, 4'b0001);
    send(32'h0000_0103, 32'h0000_1234, 3'b001, acc);
    push_done(1'b0, acc + 3);
    drain("sh_split");

    // sw crossing the top of the address space wraps to 0
    push_beat(32'hFFFF_FFFC, 32'hF00D_0000, 4'b1100);
    push_beat(32'h0000_0000, 32'h0000_CAFE, 4'b0011);
    send(32'hFFFF_FFFE, 32'hCAFE_F00D, 3'b010, acc);
    push_done(1'b0, acc + 3);
    drain("sw_wrap");

    // Ack withheld for five cycles in REQ1: port must hold steady
    mem_ack = 1'b0;
    push_beat(32'h0000_0300, 32'h1122_3344, 4'b1111);
    send(32'h0000_0300, 32'h1122_3344, 3'b010, acc);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_mem_req", {31'h0, mem_req}, 32'h1);
      chk("stall_addr", mem_addr, 32'h0000_0300);
      chk("stall_wdata", mem_wdata, 32'h1122_3344);
      chk("stall_wmask", {28'h0, mem_wmask}, 32'hF);
      chk("stall_in_ready", {31'h0, in_ready}, 32'h0);
      @(posedge clk); #1;
    end
    mem_ack = 1'b1;
    push_done(1'b0, acc + 7);
    drain("ack_stall");

    // Reset while the second beat of a split store is pending
    mem_ack = 1'b0;
    push_beat(32'h0000_0404, 32'h7800_0000, 4'b1000);
    push_beat(32'h0000_0408, 32'h0000_0056, 4'b0001);
    send(32'h0000_0407, 32'h0000_5678, 3'b001, acc);
    mem_ack = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    chk("pre_rst_in_req2", {31'h0, mem_req}, 32'h1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_mem_req", {31'h0, mem_req}, 32'h0);
    chk("post_rst_in_ready", {31'h0, in_ready}, 32'h1);
    chk("post_rst_busy", {31'h0, busy}, 32'h0);
    chk("abandoned_beat_count", beat_q.size(), 1);
    beat_q.delete();
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_no_done", {31'h0, done_valid}, 32'h0);
    end
    @(posedge clk); #1;
    mem_ack = 1'b1;

    // Illegal funct3: fault one cycle after accept, no memory access
    send(32'h0000_0500, 32'h1234_5678, 3'b011, acc);
    push_done(1'b1, acc + 1);
    drain("illegal_funct3");

    // No-split instance: misaligned sh faults; in_valid held through RESP
    // is only accepted again once the unit is back in IDLE
    in_addr1   = 32'h0000_0003;
    in_data1   = 32'h0000_1234;
    in_funct31 = 3'b001;
    in_valid1  = 1'b1;
    acc        = cyc;
    push_done1(1'b1, acc + 1);
    @(posedge clk); #1;
    chk("nosplit_ready_in_resp", {31'h0, in_ready1}, 32'h0);
    chk("nosplit_busy_in_resp", {31'h0, busy1}, 32'h1);
    @(posedge clk); #1;
    chk("nosplit_ready_in_idle", {31'h0, in_ready1}, 32'h1);
    push_done1(1'b1, acc + 3);
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    drain("nosplit_fault");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
